// File: rtl/fma_norm_round.sv
// Normalize-and-round stage of the BF16 FMA datapath: applies the LZA shift with
// one-position correction, rounds to nearest-even and packs the result in two stages.
module fma_norm_round #(
  parameter int unsigned CSIG_WIDTH = 23,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MAN_WIDTH  = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CSIG_WIDTH:0]            in_sum,
  input  logic [5:0]                     in_ld_count,
  input  logic [EXP_WIDTH+1:0]           in_exp,
  input  logic                           in_sign,
  input  logic                           in_nan,
  input  logic                           in_inf,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   out_result,
  output logic                           out_overflow,
  output logic                           out_underflow,
  output logic                           out_inexact
);

  localparam int unsigned SumW     = CSIG_WIDTH + 1;
  localparam int unsigned ExpW     = EXP_WIDTH + 2;
  localparam int unsigned KeepW    = MAN_WIDTH + 1;
  localparam int unsigned GuardPos = CSIG_WIDTH - KeepW;
  localparam int unsigned ResW     = EXP_WIDTH + MAN_WIDTH + 1;

  localparam logic [5:0]                 MaxShift = 6'(CSIG_WIDTH);
  localparam logic signed [ExpW-1:0]     ExpOvf   = ExpW'((1 << EXP_WIDTH) - 1);
  localparam logic [ResW-1:0]            QNaN     = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1,
                                                     {(MAN_WIDTH-1){1'b0}}};

  logic en1, en2;

  // Stage 1 state
  logic                 s1Valid;
  logic [SumW-1:0]      s1Sum;
  logic [ExpW-1:0]      s1Exp;
  logic                 s1Sign, s1Nan, s1Inf, s1Zero;

  // Stage 1 combinational normalize
  logic [5:0]           shAmt, totShift;
  logic [SumW-1:0]      normPre, normSum;
  logic [ExpW-1:0]      normExp;

  // Stage 2 combinational round/pack
  logic [KeepW-1:0]     keep;
  logic                 guardBit, stickyBit, roundUp, fracCarry, expNonPos;
  logic [MAN_WIDTH:0]   fracRnd;
  logic [ExpW-1:0]      rndExp;
  logic [ResW-1:0]      resNext;
  logic                 ovfNext, unfNext, inxNext;

  assign en2      = ~out_valid | out_ready;
  assign en1      = ~s1Valid | en2;
  assign in_ready = en1;

  always_comb begin
    shAmt    = (in_ld_count > MaxShift) ? MaxShift : in_ld_count;
    normPre  = in_sum << shAmt;
    // The LZA may undercount by one; a clear MSB means one more shift is needed.
    normSum  = normPre[SumW-1] ? normPre : (normPre << 1);
    totShift = shAmt + {5'd0, ~normPre[SumW-1]};
    normExp  = in_exp + ExpW'(1) - ExpW'(totShift);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1Sum   <= '0;
      s1Exp   <= '0;
      s1Sign  <= 1'b0;
      s1Nan   <= 1'b0;
      s1Inf   <= 1'b0;
      s1Zero  <= 1'b0;
    end else if (en1) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1Sum  <= normSum;
        s1Exp  <= normExp;
        s1Sign <= in_sign;
        s1Nan  <= in_nan;
        s1Inf  <= in_inf;
        s1Zero <= (in_sum == '0);
      end
    end
  end

  always_comb begin
    keep      = s1Sum[SumW-1 -: KeepW];
    guardBit  = s1Sum[GuardPos];
    stickyBit = |s1Sum[GuardPos-1:0];
    roundUp   = guardBit & (stickyBit | keep[0]);
    // Rounding the fraction alone; it carries out of the significand only with the hidden bit set.
    fracRnd   = {1'b0, keep[MAN_WIDTH-1:0]} + {{MAN_WIDTH{1'b0}}, roundUp};
    fracCarry = fracRnd[MAN_WIDTH] & keep[KeepW-1];
    rndExp    = s1Exp + ExpW'(fracCarry);
    expNonPos = rndExp[ExpW-1] | ~|rndExp;

    resNext = {s1Sign, rndExp[EXP_WIDTH-1:0], fracRnd[MAN_WIDTH-1:0]};
    ovfNext = 1'b0;
    unfNext = 1'b0;
    inxNext = guardBit | stickyBit;

    if (s1Nan) begin
      resNext = QNaN;
      inxNext = 1'b0;
    end else if (s1Inf) begin
      resNext = {s1Sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      inxNext = 1'b0;
    end else if (s1Zero) begin
      resNext = '0;
      inxNext = 1'b0;
    end else if ($signed(rndExp) >= ExpOvf) begin
      resNext = {s1Sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      ovfNext = 1'b1;
      inxNext = 1'b1;
    end else if (expNonPos) begin
      resNext = {s1Sign, {(ResW-1){1'b0}}};
      unfNext = 1'b1;
      inxNext = |keep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (en2) begin
      out_valid <= s1Valid;
      if (s1Valid) begin
        out_result    <= resNext;
        out_overflow  <= ovfNext;
        out_underflow <= unfNext;
        out_inexact   <= inxNext;
      end
    end
  end

endmodule

// File: tb/tb_fma_norm_round.sv
// Bench for fma_norm_round: arithmetic reference model with a scoreboard checked every
// cycle, plus directed vectors with hand-computed results.
module tb_fma_norm_round;

  typedef struct packed {
    logic [15:0] res;
    logic        ov;
    logic        un;
    logic        ix;
  } exp_t;

  typedef struct packed {
    logic [23:0] sum;
    logic [5:0]  ld;
    logic [9:0]  ex;
    logic        sg;
    logic        nan;
    logic        inf;
    logic [18:0] want;
  } vec_t;

  localparam int NV = 13;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_sum;
  logic [5:0]  in_ld_count;
  logic [9:0]  in_exp;
  logic        in_sign;
  logic        in_nan;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int   nTests = 0;
  int   nFail  = 0;
  exp_t q[$];
  bit   randOr = 0;

  vec_t vecs [NV] = '{
    '{24'h800000, 6'd0,  10'd126, 1'b0, 1'b0, 1'b0, {16'h3F80, 3'b000}},
    '{24'h400000, 6'd0,  10'd126, 1'b0, 1'b0, 1'b0, {16'h3F00, 3'b000}},
    '{24'h000001, 6'd23, 10'd149, 1'b0, 1'b0, 1'b0, {16'h3F80, 3'b000}},
    '{24'h818000, 6'd0,  10'd126, 1'b0, 1'b0, 1'b0, {16'h3F82, 3'b001}},
    '{24'h808000, 6'd0,  10'd126, 1'b0, 1'b0, 1'b0, {16'h3F80, 3'b001}},
    '{24'hFF8000, 6'd0,  10'd126, 1'b0, 1'b0, 1'b0, {16'h4000, 3'b001}},
    '{24'h800000, 6'd0,  10'd254, 1'b0, 1'b0, 1'b0, {16'h7F80, 3'b101}},
    '{24'h800000, 6'd0,  10'h3FF, 1'b0, 1'b0, 1'b0, {16'h0000, 3'b011}},
    '{24'h800000, 6'd0,  10'd126, 1'b0, 1'b1, 1'b0, {16'h7FC0, 3'b000}},
    '{24'h800000, 6'd0,  10'd126, 1'b1, 1'b0, 1'b1, {16'hFF80, 3'b000}},
    '{24'h000000, 6'd0,  10'd126, 1'b0, 1'b0, 1'b0, {16'h0000, 3'b000}},
    '{24'h000001, 6'd40, 10'd149, 1'b0, 1'b0, 1'b0, {16'h3F80, 3'b000}},
    '{24'hFF8000, 6'd0,  10'd253, 1'b0, 1'b0, 1'b0, {16'h7F80, 3'b101}}
  };

  fma_norm_round dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_ld_count   (in_ld_count),
    .in_exp        (in_exp),
    .in_sign       (in_sign),
    .in_nan        (in_nan),
    .in_inf        (in_inf),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nTests++;
    if (act !== want) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int wrap10(input int x);
    int y;
    y = x & 1023;
    if (y >= 512) y -= 1024;
    return y;
  endfunction

  // Reference: value-level normalize, remainder-based round-to-nearest-even, range classify.
  function automatic exp_t model(input vec_t v);
    exp_t   r;
    longint n;
    int     sh, tot, e, k, rem, kr;
    bit     up;
    r = '0;
    if (v.nan) begin
      r.res = 16'h7FC0;
      return r;
    end
    if (v.inf) begin
      r.res = {v.sg, 15'h7F80};
      return r;
    end
    if (v.sum == 24'd0) return r;
    sh  = (int'(v.ld) > 23) ? 23 : int'(v.ld);
    n   = (longint'(v.sum) << sh) & 64'hFFFFFF;
    tot = sh;
    if (n < 64'h800000) begin
      n   = (n * 2) & 64'hFFFFFF;
      tot = tot + 1;
    end
    e   = wrap10(int'($signed(v.ex)) + 1 - tot);
    k   = int'(n / 65536);
    rem = int'(n % 65536);
    up  = (rem > 32768) || (rem == 32768 && (k % 2) == 1);
    kr  = k + int'(up);
    if (kr == 256) begin
      kr = 128;
      e  = wrap10(e + 1);
    end
    if (e >= 255) begin
      r.res = {v.sg, 8'hFF, 7'h00};
      r.ov  = 1'b1;
      r.ix  = 1'b1;
    end else if (e <= 0) begin
      r.res = {v.sg, 15'h0000};
      r.un  = 1'b1;
      r.ix  = (k != 0);
    end else begin
      r.res = {v.sg, 8'(e), 7'(kr)};
      r.ix  = (rem != 0);
    end
    return r;
  endfunction

  function automatic vec_t randVec();
    vec_t        v;
    logic [23:0] m;
    int          s, r;
    v = '0;
    r = $urandom_range(0, 99);
    m = {1'b1, 23'($urandom)};
    if ($urandom_range(0, 3) == 0) m[15:0] = 16'h8000;
    if ($urandom_range(0, 5) == 0) m[22:16] = 7'h7F;
    s = $urandom_range(0, 23);
    v.sum = m >> s;
    v.ld  = 6'(s);
    if (s > 0 && $urandom_range(0, 1) == 1) v.ld = 6'(s - 1);
    if (r < 4) v.ld = 6'($urandom_range(0, 63));
    if (r >= 4 && r < 8) v.sum = 24'd0;
    if ($urandom_range(0, 4) == 0) v.ex = 10'($urandom);
    else v.ex = 10'($urandom_range(0, 320) - 20);
    v.sg  = 1'($urandom);
    v.nan = (r >= 94 && r < 97);
    v.inf = (r >= 96);
    return v;
  endfunction

  task automatic setIn(input vec_t v);
    in_sum      = v.sum;
    in_ld_count = v.ld;
    in_exp      = v.ex;
    in_sign     = v.sg;
    in_nan      = v.nan;
    in_inf      = v.inf;
    in_valid    = 1'b1;
  endtask

  // Offer a beat and return just after the edge that accepts it.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    setIn(v);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_accept", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk(name, q.size(), 32'd0);
  endtask

  // Scoreboard: check the head every cycle the output is valid, retire it on transfer.
  initial begin
    vec_t cur;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          chk("out_unexpected", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("out_beat", {13'd0, out_result, out_overflow, out_underflow, out_inexact},
              {13'd0, q[0]});
          if (out_ready) void'(q.pop_front());
        end
      end
      if (rst_n && in_valid && in_ready) begin
        cur = '0;
        cur.sum = in_sum;
        cur.ld  = in_ld_count;
        cur.ex  = in_exp;
        cur.sg  = in_sign;
        cur.nan = in_nan;
        cur.inf = in_inf;
        q.push_back(model(cur));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randOr) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", nFail);
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sum      = '0;
    in_ld_count = '0;
    in_exp      = '0;
    in_sign     = 1'b0;
    in_nan      = 1'b0;
    in_inf      = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    chk("rst_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("model_pin_%0d", i), {13'd0, model(vecs[i])}, {13'd0, vecs[i].want});
    end

    // Latency: valid two edges after the accepting edge.
    send(vecs[0]);
    in_valid = 1'b0;
    chk("lat_edge1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_edge2", {31'd0, out_valid}, 32'd1);
    waitDrain("drain_latency");

    for (int i = 0; i < NV; i++) send(vecs[i]);
    in_valid = 1'b0;
    waitDrain("drain_directed");

    // Backpressure: two beats held, input stalls, then four results back to back.
    out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[4]);
    setIn(vecs[5]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    chk("bp_accepted", q.size(), 32'd2);
    @(posedge clk);
    #1 out_ready = 1'b1;
    fork
      begin
        send(vecs[5]);
        send(vecs[6]);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_stream_valid", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    @(negedge clk);
    #1;
    chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_done_queue", q.size(), 32'd0);

    // Asynchronous reset with two beats in flight.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(vecs[3]);
    send(vecs[5]);
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_result", {16'd0, out_result}, 32'd0);
    chk("arst_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(vecs[12]);
    in_valid = 1'b0;
    waitDrain("drain_post_reset");

    // Random traffic with random consumer stalls.
    randOr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(randVec());
      if ($urandom_range(0, 4) == 0) in_valid = 1'b0;
      if (!in_valid) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    randOr   = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    waitDrain("drain_random");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
